// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: frames read/write requests onto a register port.
// Build option: MDIO_SLAVE_PREAMBLE_SUPPRESS_EN accepts ST after any preamble.
module mdio_slave #(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_SKIP
    } state_t;

    state_t      state;
    logic        mdc_s1;
    logic        mdc_s2;
    logic        mdc_s3;
    logic        mdio_s1;
    logic        mdio_s2;
    logic        bit_ev;
    logic        bit_in;
    logic        pre_ok;
    logic        is_rd;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic [3:0]  fld;
    logic [15:0] sh;

    assign bit_ev = mdc_s2 & ~mdc_s3;
    assign bit_in = mdio_s2;

`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
    assign pre_ok = (pre_cnt != 6'd0);
`else
    assign pre_ok = (pre_cnt == 6'd32);
`endif

    // Bring MDC and MDIO into the clk domain; mdc_s3 only feeds edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_s3  <= 1'b0;
            mdio_s1 <= 1'b0;
            mdio_s2 <= 1'b0;
        end else begin
            mdc_s1  <= mdc_i;
            mdc_s2  <= mdc_s1;
            mdc_s3  <= mdc_s2;
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    // Frame sequencer; every state change happens on an MDC rising event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PRE;
            pre_cnt   <= 6'd0;
            bit_cnt   <= 5'd0;
            fld       <= 4'd0;
            is_rd     <= 1'b0;
            sh        <= 16'd0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            reg_addr  <= 5'd0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_wdata <= 16'd0;
            frame_err <= 1'b0;
        end else begin
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            frame_err <= 1'b0;
            // Read data arrives the clk after the request pulse.
            if (reg_rd) begin
                sh <= reg_rdata;
            end
            if (bit_ev) begin
                unique case (state)
                    S_PRE: begin
                        if (bit_in) begin
                            if (pre_cnt != 6'd32) begin
                                pre_cnt <= pre_cnt + 6'd1;
                            end
                        end else begin
                            pre_cnt <= 6'd0;
                            if (pre_ok) begin
                                state <= S_ST;
                            end
                        end
                    end
                    S_ST: begin
                        bit_cnt <= 5'd0;
                        if (bit_in) begin
                            state <= S_OP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_PRE;
                            pre_cnt   <= 6'd0;
                        end
                    end
                    S_OP: begin
                        fld <= {fld[2:0], bit_in};
                        if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= 5'd0;
                            unique case ({fld[0], bit_in})
                                2'b10: begin
                                    is_rd <= 1'b1;
                                    state <= S_PHYAD;
                                end
                                2'b01: begin
                                    is_rd <= 1'b0;
                                    state <= S_PHYAD;
                                end
                                default: begin
                                    frame_err <= 1'b1;
                                    state     <= S_PRE;
                                    pre_cnt   <= 6'd0;
                                end
                            endcase
                        end
                    end
                    S_PHYAD: begin
                        fld <= {fld[2:0], bit_in};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= 5'd0;
                            if ({fld, bit_in} == PHY_ADDR) begin
                                state <= S_REGAD;
                            end else begin
                                state <= S_SKIP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_REGAD: begin
                        fld <= {fld[2:0], bit_in};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt  <= 5'd0;
                            reg_addr <= {fld, bit_in};
                            reg_rd   <= is_rd;
                            state    <= S_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_TA: begin
                        if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= 5'd0;
                            state   <= S_DATA;
                            if (is_rd) begin
                                mdio_oe <= 1'b1;
                                mdio_o  <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (is_rd) begin
                            if (bit_cnt == 5'd16) begin
                                mdio_oe <= 1'b0;
                                mdio_o  <= 1'b1;
                                bit_cnt <= 5'd0;
                                pre_cnt <= 6'd0;
                                state   <= S_PRE;
                            end else begin
                                mdio_o  <= sh[15];
                                sh      <= {sh[14:0], 1'b0};
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end else begin
                            sh <= {sh[14:0], bit_in};
                            if (bit_cnt == 5'd15) begin
                                reg_wdata <= {sh[14:0], bit_in};
                                reg_wr    <= 1'b1;
                                bit_cnt   <= 5'd0;
                                pre_cnt   <= 6'd0;
                                state     <= S_PRE;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_SKIP: begin
                        if (bit_cnt == 5'd17) begin
                            bit_cnt <= 5'd0;
                            pre_cnt <= 6'd0;
                            state   <= S_PRE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    default: begin
                        state   <= S_PRE;
                        pre_cnt <= 6'd0;
                    end
                endcase
            end
        end
    end

endmodule
